// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, error codes and command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_tx_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NOACK   = 2'b10;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for PS2C/PS2D plus a falling-edge pulse on synchronized PS2C.
// Shared with the keyboard receiver; synchronizers reset to the idle-high line level.
module ps2_sync_edge (
    input  logic clk,
    input  logic srst,
    input  logic ps2c_i,
    input  logic ps2d_i,
    output logic ps2c_s,
    output logic ps2d_s,
    output logic ps2c_fall
);

    logic [1:0] pin_in;
    logic [1:0] sync_vec;
    logic       ps2c_prev_q;

    assign pin_in = {ps2d_i, ps2c_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_q;
            logic sync_q;
            always_ff @(posedge clk) begin
                if (srst) begin
                    meta_q <= 1'b1;
                    sync_q <= 1'b1;
                end else begin
                    meta_q <= pin_in[gi];
                    sync_q <= meta_q;
                end
            end
            assign sync_vec[gi] = sync_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            ps2c_prev_q <= 1'b1;
        end else begin
            ps2c_prev_q <= sync_vec[0];
        end
    end

    assign ps2c_s    = sync_vec[0];
    assign ps2d_s    = sync_vec[1];
    assign ps2c_fall = ps2c_prev_q & ~sync_vec[0];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, request-to-send, shift, ACK, idle wait).
// Define PS2_TX_ACK_CHECK_EN to report a missing device ACK as err_code 10.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = 10000,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    input  logic       ps2c_i,
    input  logic       ps2d_i,
    output logic       ps2c_oe,
    output logic       ps2d_oe
);

`ifdef PS2_TX_ACK_CHECK_EN
    localparam bit ACK_CHECK = 1'b1;
`else
    localparam bit ACK_CHECK = 1'b0;
`endif

    localparam int CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

    logic ps2c_s, ps2d_s, ps2c_fall;

    ps2_sync_edge u_sync (
        .clk       (clk),
        .srst      (rst),
        .ps2c_i    (ps2c_i),
        .ps2d_i    (ps2d_i),
        .ps2c_s    (ps2c_s),
        .ps2d_s    (ps2d_s),
        .ps2c_fall (ps2c_fall)
    );

    ps2_tx_state_e    state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             parity_q, parity_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ps2c_oe_q, ps2c_oe_d;
    logic             ps2d_oe_q, ps2d_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             ack_bad_q, ack_bad_d;
    logic             watch;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        cnt_d      = cnt_q;
        ps2c_oe_d  = ps2c_oe_q;
        ps2d_oe_d  = ps2d_oe_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        ack_bad_d  = ack_bad_q;
        watch      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ps2c_oe_d = 1'b0;
                ps2d_oe_d = 1'b0;
                // busy_q is still high in the done/err cycle, so a start there is ignored
                busy_d    = 1'b0;
                if (tx_start && !busy_q) begin
                    data_d    = tx_data;
                    parity_d  = odd_parity(tx_data);
                    bit_cnt_d = 4'd0;
                    ack_bad_d = 1'b0;
                    cnt_d     = INHIBIT_LOAD;
                    ps2c_oe_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == '0) begin
                    ps2d_oe_d = 1'b1;
                    state_d   = ST_START;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_START: begin
                ps2c_oe_d = 1'b0;
                cnt_d     = TIMEOUT_LOAD;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (ps2c_fall) begin
                    cnt_d     = TIMEOUT_LOAD;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd8) begin
                        ps2d_oe_d = ~data_q[bit_cnt_q[2:0]];
                    end else if (bit_cnt_q == 4'd8) begin
                        ps2d_oe_d = ~parity_q;
                    end else begin
                        ps2d_oe_d = 1'b0;
                        state_d   = ST_ACK;
                    end
                end else begin
                    watch = 1'b1;
                end
            end
            ST_ACK: begin
                if (ps2c_fall) begin
                    cnt_d     = TIMEOUT_LOAD;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    ack_bad_d = ps2d_s;
                    state_d   = ST_WAIT_IDLE;
                end else begin
                    watch = 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (ps2c_s && ps2d_s) begin
                    state_d = ST_IDLE;
                    if (ACK_CHECK && ack_bad_q) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_NOACK;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (ps2c_fall) begin
                    cnt_d = TIMEOUT_LOAD;
                end else begin
                    watch = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Shared watchdog for every state that waits on the device
        if (watch) begin
            if (cnt_q == '0) begin
                state_d    = ST_IDLE;
                ps2c_oe_d  = 1'b0;
                ps2d_oe_d  = 1'b0;
                err_d      = 1'b1;
                err_code_d = ERR_TIMEOUT;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            data_q     <= 8'h00;
            parity_q   <= 1'b0;
            bit_cnt_q  <= 4'd0;
            cnt_q      <= '0;
            ps2c_oe_q  <= 1'b0;
            ps2d_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            ack_bad_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            cnt_q      <= cnt_d;
            ps2c_oe_q  <= ps2c_oe_d;
            ps2d_oe_q  <= ps2d_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            ack_bad_q  <= ack_bad_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign ps2c_oe  = ps2c_oe_q;
    assign ps2d_oe  = ps2d_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboarded bench for ps2_host_tx with an open-drain PS/2 keyboard model.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 10000;
    localparam int TO   = 2000;
    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       busy, done, err;
    logic [1:0] err_code;
    logic       ps2c_oe, ps2d_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2c_i, ps2d_i;

    assign ps2c_i = dev_clk & ~ps2c_oe;
    assign ps2d_i = dev_data & ~ps2d_oe;

    ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .ps2c_i   (ps2c_i),
        .ps2d_i   (ps2d_i),
        .ps2c_oe  (ps2c_oe),
        .ps2d_oe  (ps2d_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [1:0] code;
        bit         has_frame;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic       start;
        logic [7:0] data;
        logic       parity;
        logic       stop;
    } frame_t;

    exp_t   exp_q[$];
    frame_t frame_q[$];

    int     n_checks = 0;
    int     n_errors = 0;
    int     resp_cnt = 0;
    longint cyc = 0;
    longint resp_cyc = 0;
    longint stall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input longint act, input longint expv);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Odd parity: the parity bit makes the total count of ones odd
    function automatic logic exp_parity(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    // Response monitor / scoreboard
    bit check_busy_low = 1'b0;
    always @(negedge clk) begin
        exp_t   e;
        frame_t f;
        if (check_busy_low) begin
            chk(busy == 1'b0, "busy_after_resp", busy, 0);
            check_busy_low = 1'b0;
        end
        if (done || err) begin
            resp_cnt++;
            resp_cyc = cyc;
            check_busy_low = 1'b1;
            chk(!(done && err), "done_err_exclusive", {done, err}, 2);
            chk(busy == 1'b1, "busy_in_resp", busy, 1);
            chk(ps2c_oe == 1'b0 && ps2d_oe == 1'b0, "oe_released", {ps2c_oe, ps2d_oe}, 0);
            chk(exp_q.size() != 0, "unexpected_resp", {done, err}, 0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(err == e.is_err, "resp_kind_err", err, e.is_err);
                if (e.is_err) chk(err_code == e.code, "err_code", err_code, e.code);
                if (e.has_frame) begin
                    chk(frame_q.size() != 0, "frame_present", frame_q.size(), 1);
                    if (frame_q.size() != 0) begin
                        f = frame_q.pop_front();
                        chk(f.start == 1'b0, "start_bit", f.start, 0);
                        chk(f.data == e.data, "wire_data", f.data, e.data);
                        chk(f.parity == exp_parity(e.data), "parity_bit", f.parity, exp_parity(e.data));
                        chk(f.stop == 1'b1, "stop_bit", f.stop, 1);
                    end
                end
            end
        end
    end

    // Inhibit / request-to-send timing checker
    int inh_run = 0;
    int start_run = 0;
    always @(negedge clk) begin
        if (rst) begin
            inh_run = 0;
            start_run = 0;
        end else if (ps2c_oe && !ps2d_oe) begin
            inh_run++;
        end else if (ps2c_oe && ps2d_oe) begin
            if (inh_run != 0) chk(inh_run == INH, "inhibit_len", inh_run, INH);
            inh_run = 0;
            start_run++;
        end else begin
            if (start_run != 0) chk(start_run == 1, "start_len", start_run, 1);
            start_run = 0;
            inh_run = 0;
        end
    end

    task automatic send(input logic [7:0] b, input bit push, input bit is_err,
                        input logic [1:0] code, input bit has_frame);
        exp_t e;
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        chk(busy == 1'b1, "busy_after_accept", busy, 1);
        if (push) begin
            e.is_err    = is_err;
            e.code      = code;
            e.has_frame = has_frame;
            e.data      = b;
            exp_q.push_back(e);
        end
    endtask

    // mode: 0 = ACK, 1 = stop clocking after edge 5, 2 = no ACK, 3 = stop after edge 3
    task automatic device_run(input int mode);
        frame_t f;
        int     waited;
        waited = 0;
        while (!(ps2c_oe == 1'b0 && ps2d_oe == 1'b1) && waited < INH + 200) begin
            @(negedge clk);
            waited++;
        end
        chk(ps2c_oe == 1'b0 && ps2d_oe == 1'b1, "rts_seen", waited, INH);
        if (!(ps2c_oe == 1'b0 && ps2d_oe == 1'b1)) return;
        repeat (HALF) @(negedge clk);
        f.start = ps2d_i;
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            if (k == 5) stall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (k <= 8) begin
                f.data[k-1] = ps2d_i;
            end else if (k == 9) begin
                f.parity = ps2d_i;
            end else if (k == 10) begin
                f.stop = ps2d_i;
                frame_q.push_back(f);
                dev_data = (mode == 2);
            end
            if (mode == 1 && k == 5) return;
            if (mode == 3 && k == 3) return;
            repeat (HALF) @(negedge clk);
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_resp(input int target, input int bound);
        int w;
        w = 0;
        while (resp_cnt < target && w < bound) begin
            @(negedge clk);
            w++;
        end
        chk(resp_cnt >= target, "resp_wait", resp_cnt, target);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rb;
        longint     delta;
        int         base;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk(busy == 1'b0, "rst_busy", busy, 0);
        chk(done == 1'b0, "rst_done", done, 0);
        chk(err == 1'b0, "rst_err", err, 0);
        chk(err_code == 2'b00, "rst_err_code", err_code, 0);
        chk(ps2c_oe == 1'b0, "rst_ps2c_oe", ps2c_oe, 0);
        chk(ps2d_oe == 1'b0, "rst_ps2d_oe", ps2d_oe, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 0xED with ACK, plus a second start request while busy
        send(CMD_SET_LEDS, 1'b1, 1'b0, 2'b00, 1'b1);
        repeat (20) @(negedge clk);
        tx_data  = CMD_RESET;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        device_run(0);
        wait_resp(1, 400);
        $display("txn 1: sent 0x%02h (retrigger 0x%02h ignored) responses=%0d", CMD_SET_LEDS, CMD_RESET, resp_cnt);

        // 0xF4 with ACK (parity 0)
        send(CMD_ENABLE, 1'b1, 1'b0, 2'b00, 1'b1);
        device_run(0);
        wait_resp(2, 400);
        $display("txn 2: sent 0x%02h responses=%0d", CMD_ENABLE, resp_cnt);

        // Random byte with ACK
        rb = 8'($urandom_range(0, 255));
        send(rb, 1'b1, 1'b0, 2'b00, 1'b1);
        device_run(0);
        wait_resp(3, 400);
        $display("txn 3: sent 0x%02h responses=%0d", rb, resp_cnt);

        // Device stops clocking after edge 5 -> timeout
        rb = 8'($urandom_range(0, 255));
        send(rb, 1'b1, 1'b1, ERR_TIMEOUT, 1'b0);
        device_run(1);
        wait_resp(4, TO + 200);
        delta = resp_cyc - stall_cyc;
        chk(delta >= TO && delta <= TO + 4, "timeout_latency", delta, TO);
        $display("txn 4: sent 0x%02h stalled after edge 5, err after %0d cycles", rb, delta);

        // Device leaves PS2D high at the ACK slot
        rb = 8'($urandom_range(0, 255));
`ifdef PS2_TX_ACK_CHECK_EN
        send(rb, 1'b1, 1'b1, ERR_NOACK, 1'b1);
`else
        send(rb, 1'b1, 1'b0, 2'b00, 1'b1);
`endif
        device_run(2);
        wait_resp(5, 400);
        $display("txn 5: sent 0x%02h without ACK responses=%0d", rb, resp_cnt);

        // Reset in the middle of the shift phase
        rb = 8'($urandom_range(0, 255));
        send(rb, 1'b0, 1'b0, 2'b00, 1'b0);
        device_run(3);
        base = resp_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk(ps2c_oe == 1'b0, "midrst_ps2c_oe", ps2c_oe, 0);
        chk(ps2d_oe == 1'b0, "midrst_ps2d_oe", ps2d_oe, 0);
        chk(busy == 1'b0, "midrst_busy", busy, 0);
        chk(done == 1'b0 && err == 1'b0, "midrst_no_pulse", {done, err}, 0);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk(resp_cnt == base, "midrst_no_resp", resp_cnt, base);
        chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        $display("txn 6: sent 0x%02h, reset during shift, responses=%0d", rb, resp_cnt);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYC, default 10000, meaning clk cycles PS2C is held low before the start bit (100 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 2000000, meaning the maximum clk cycles allowed between device clock falling edges, or while waiting for idle (20 ms).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port tx_data, input, 8 bits: the command byte to send to the keyboard (e.g. 0xED LED set).
REQ-006 SHALL have port tx_start, input, 1 bit: request strobe; accepted only when busy=0.
REQ-007 SHALL have port busy, output, 1 bit: high from the cycle after acceptance until done or err is pulsed.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse on successful completion.
REQ-009 SHALL have port err, output, 1 bit: one-cycle pulse on failure.
REQ-010 SHALL have port err_code, output, 2 bits: 01 = timeout, 10 = no acknowledge; valid while err=1, otherwise held.
REQ-011 SHALL have port ps2c_i, input, 1 bit: raw PS2C pin level (asynchronous).
REQ-012 SHALL have port ps2d_i, input, 1 bit: raw PS2D pin level (asynchronous).
REQ-013 SHALL have port ps2c_oe, output, 1 bit: 1 = drive PS2C low; 0 = release (open drain).
REQ-014 SHALL have port ps2d_oe, output, 1 bit: 1 = drive PS2D low; 0 = release (open drain).

Function
REQ-015 SHALL synchronize ps2c_i and ps2d_i through 2 flops each, and detect PS2C falling edges on the synchronized signal.
REQ-016 SHALL, on tx_start=1 with busy=0, latch tx_data, compute odd parity (~^tx_data), and enter INHIBIT.
REQ-017 SHALL ignore tx_start while busy=1.
REQ-018 SHALL define the states as follows:
- IDLE: both outputs 0.
- INHIBIT: ps2c_oe=1 for exactly INHIBIT_CYC cycles.
- START: ps2d_oe=1 and ps2c_oe=1 for 1 cycle, then ps2c_oe=0.
- SHIFT: waits on device clock edges.
- ACK: samples the acknowledge bit.
- WAIT_IDLE: waits for both lines high.
REQ-019 SHALL, in SHIFT, update ps2d_oe on falling edges 1-8 to ~data[n] (LSB first), on edge 9 to ~parity, and on edge 10 to 0 (stop bit, line released).
REQ-020 SHALL, on falling edge 11, sample synchronized PS2D; 0 = ACK good.
REQ-021 SHALL, in WAIT_IDLE, assert done one cycle after both synchronized lines read 1, then return to IDLE.
REQ-022 SHALL reload the timeout counter on entry to SHIFT and on every falling edge; on expiry in SHIFT, ACK or WAIT_IDLE it releases both lines, pulses err with code 01, and enters IDLE.
REQ-023 SHALL assert busy from the cycle after acceptance through the done/err cycle inclusive; done and err are never high together.
REQ-024 SHALL ignore falling edges seen during INHIBIT or START.

Reset
REQ-025 SHALL, on rst=1, force state=IDLE, ps2c_oe=0, ps2d_oe=0, busy=0, done=0, err=0, err_code=00, bit counter=0, synchronizers=1, on the next clk edge.
REQ-026 SHALL, on reset mid-transfer, release both lines within one cycle with no done/err pulse.

Configuration
REQ-027 SHALL, with PS2_TX_ACK_CHECK_EN defined, on a failed ACK (sampled PS2D=1) pulse err with code 10 instead of done, after lines are idle.
REQ-028 SHALL, without PS2_TX_ACK_CHECK_EN, ignore the ACK value: edge 11 always proceeds to WAIT_IDLE and done, and err_code 10 never occurs.

Structure
REQ-029 SHALL place the state enumeration, err_code constants (ERR_TIMEOUT=2'b01, ERR_NOACK=2'b10) and the PS/2 command constants (0xED, 0xF4, 0xFF) in a shared ps2_pkg package.
REQ-030 SHALL instantiate one sub-module, ps2_sync_edge, which provides the 2-flop synchronizer and the falling-edge pulse, so it can be reused by the keyboard receiver.

Verification
REQ-031 SHALL cover: send 0xED with a device model that ACKs -> ps2c_oe held exactly 10000 cycles; data bits 1,0,1,1,0,1,1,1 (LSB first); parity 1; stop released; done pulse once; busy low the next cycle.
REQ-032 SHALL cover: send 0xF4 -> parity bit 0, done pulse.
REQ-033 SHALL cover: device stops clocking after edge 5 -> err=1 with err_code=01 TIMEOUT_CYC cycles after edge 5; both oe=0.
REQ-034 SHALL cover: device leaves PS2D high on edge 11 -> err, code 10 with PS2_TX_ACK_CHECK_EN defined; done without it.
REQ-035 SHALL cover: tx_start pulsed again while busy -> no effect, tx_data unchanged on the wire.
REQ-036 SHALL cover: rst asserted during SHIFT -> next cycle ps2c_oe=ps2d_oe=0, busy=0, no done/err pulse.
